// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// mult/multu take 5 cycles and div/divu take 10; mthi/mtlo write in a single edge.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned W       = 32;
  localparam int unsigned CW      = 4;
  localparam int unsigned MUL_CYC = 5;
  localparam int unsigned DIV_CYC = 10;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            uns_q, uns_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic [2*W-1:0]  ext_a, ext_b, prod;
  logic            neg_a, neg_b;
  logic [W-1:0]    abs_a, abs_b;
  logic [W-1:0]    uquo, urem;
  logic [W-1:0]    quo, rem;
  logic            done;

  // Arithmetic on the latched operands; only sampled into HI/LO on completion
  always_comb begin
    ext_a = uns_q ? {{W{1'b0}}, a_q} : {{W{a_q[W-1]}}, a_q};
    ext_b = uns_q ? {{W{1'b0}}, b_q} : {{W{b_q[W-1]}}, b_q};
    prod  = ext_a * ext_b;

    // Sign-magnitude division: the most negative dividend over -1 wraps back to itself
    neg_a = !uns_q && a_q[W-1];
    neg_b = !uns_q && b_q[W-1];
    abs_a = neg_a ? W'(-a_q) : a_q;
    abs_b = neg_b ? W'(-b_q) : b_q;
    if (abs_b == '0) begin
      uquo = '0;
      urem = '0;
    end else begin
      uquo = abs_a / abs_b;
      urem = abs_a % abs_b;
    end
    quo = (neg_a ^ neg_b) ? W'(-uquo) : uquo;
    rem = neg_a ? W'(-urem) : urem;
  end

  assign done = (state_q != S_IDLE) && (cnt_q == CW'(1));

  // State, counter, operand, busy and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      uns_q   <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      uns_q   <= uns_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state: accept new work only in IDLE, count down while busy
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    uns_d   = uns_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          unique case (MDOp)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = CW'(MUL_CYC);
              a_d     = A;
              b_d     = B;
              uns_d   = MDOp[0];
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = CW'(DIV_CYC);
              a_d     = A;
              b_d     = B;
              uns_d   = MDOp[0];
            end
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: mthi/mtlo in IDLE, result write on the completion edge, busy from next state
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = (state_d != S_IDLE);
    if (state_q == S_IDLE && Start) begin
      if (MDOp == OP_MTHI) hi_d = A;
      if (MDOp == OP_MTLO) lo_d = A;
    end
    if (done) begin
      if (state_q == S_MUL) begin
        hi_d = prod[2*W-1:W];
        lo_d = prod[W-1:0];
      end else if (b_q != '0) begin
        hi_d = rem;
        lo_d = quo;
      end
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, busy timing, ignore rules, reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble operands afterwards, and check Busy over n cycles then its fall
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    Start = 1'b1; MDOp = op; A = a; B = b;
    tick();
    Start = 1'b0; A = $urandom; B = $urandom;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      tick();
    end
    check({tag, "_done"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = 3'b000; A = '0; B = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);

    // signed mult -2 * 3, HI held until completion
    Start = 1'b1; MDOp = 3'b000; A = 32'hFFFFFFFE; B = 32'd3;
    tick();
    Start = 1'b0; A = 32'h11111111; B = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      check("mult_busy", 32'(Busy), 32'd1);
      check("mult_hold_hi", HI, 32'h0);
      tick();
    end
    check("mult_done", 32'(Busy), 32'd0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFA);

    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    check("multu_hi", HI, 32'hFFFFFFFE);
    check("multu_lo", LO, 32'h00000001);

    run_op("divu", 3'b011, 32'd100, 32'd7, 10);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 10);
    check("div_neg_lo", LO, 32'hFFFFFFFD);
    check("div_neg_hi", HI, 32'hFFFFFFFF);

    run_op("div_negb", 3'b010, 32'd7, 32'hFFFFFFFE, 10);
    check("div_negb_lo", LO, 32'hFFFFFFFD);
    check("div_negb_hi", HI, 32'h00000001);

    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10);
    check("div_ovf_lo", LO, 32'h80000000);
    check("div_ovf_hi", HI, 32'h00000000);

    // mthi / mtlo preload
    Start = 1'b1; MDOp = 3'b100; A = 32'h1234;
    tick();
    check("mthi_busy", 32'(Busy), 32'd0);
    check("mthi_hi", HI, 32'h1234);
    MDOp = 3'b101; A = 32'h5678;
    tick();
    Start = 1'b0;
    check("mtlo_busy", 32'(Busy), 32'd0);
    check("mtlo_lo", LO, 32'h5678);
    check("mtlo_hi", HI, 32'h1234);

    // no-op encodings
    Start = 1'b1; MDOp = 3'b110; A = 32'hAAAA;
    tick();
    MDOp = 3'b111;
    tick();
    Start = 1'b0;
    check("nop_busy", 32'(Busy), 32'd0);
    check("nop_hi", HI, 32'h1234);
    check("nop_lo", LO, 32'h5678);

    // divide by zero: full busy time, HI/LO untouched
    run_op("div0", 3'b010, 32'd55, 32'd0, 10);
    check("div0_hi", HI, 32'h1234);
    check("div0_lo", LO, 32'h5678);

    // mthi during mult ignored; mtlo on the busy-falling cycle ignored
    Start = 1'b1; MDOp = 3'b000; A = 32'd6; B = 32'd7;
    tick();
    MDOp = 3'b100; A = 32'hDEAD;
    tick();
    Start = 1'b0;
    check("mid_mthi_hi", HI, 32'h1234);
    check("mid_mthi_busy", 32'(Busy), 32'd1);
    tick();
    tick();
    tick();
    check("late_busy", 32'(Busy), 32'd1);
    Start = 1'b1; MDOp = 3'b101; A = 32'hBEEF;
    tick();
    Start = 1'b0;
    check("ign_busy", 32'(Busy), 32'd0);
    check("ign_hi", HI, 32'h0);
    check("ign_lo", LO, 32'd42);
    tick();
    check("ign_after_lo", LO, 32'd42);
    check("ign_after_busy", 32'(Busy), 32'd0);

    // reset mid-divide aborts with no later write
    Start = 1'b1; MDOp = 3'b011; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_late_busy", 32'(Busy), 32'd0);
    check("abort_late_hi", HI, 32'h0);
    check("abort_late_lo", LO, 32'h0);

    // reset wins over Start
    reset = 1'b1; Start = 1'b1; MDOp = 3'b100; A = 32'h77;
    tick();
    reset = 1'b0; Start = 1'b0;
    check("rst_prio_busy", 32'(Busy), 32'd0);
    check("rst_prio_hi", HI, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
